adc_volts_reader: RTL

Serial read-back engine for the DAC/ADC sweep path: the DAC counter side sets an output voltage, and this block reads the resulting conversion from a 12-bit SPI ADC. On a start request it runs 2^AvgLog2 ADC frames (CS/SCLK master, MISO capture) and accumulates the samples. It then presents the truncated average with a one-cycle valid pulse, and flags any frame whose leading zero bits were corrupted. It sits between the sweep control FSM and the result logging/UART path.

---
 rtl/adc_pkg.sv | 29 ++
 rtl/spi_clk_div.sv | 46 ++++
 rtl/adc_volts_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared encodings and frame geometry for the SPI ADC read-back path.
// Used by the top and by the sweep FSM timeout logic.
package adc_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CS_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT    = 3'd2;
   localparam logic [2:0] ST_CS_HOLD  = 3'd3;
   localparam logic [2:0] ST_QUIET    = 3'd4;
   localparam logic [2:0] ST_DONE     = 3'd5;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      CS_SETUP = ST_CS_SETUP,
      SHIFT    = ST_SHIFT,
      CS_HOLD  = ST_CS_HOLD,
      QUIET    = ST_QUIET,
      DONE     = ST_DONE
   } state_t;

   localparam int FRAME_BITS = 16;
   localparam int LEAD_ZEROS = 4;

   // setup + 2*FRAME_BITS shift halves + hold + two quiet halves, in clk cycles
   function automatic int frame_cycles(input int div_half);
      return (1 + 2 * FRAME_BITS + 1 + 2) * div_half;
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: DivHalf-cycle half periods, idles high, first half-period low.
// Zero latency on enable; rise_o is high the cycle before sclk_o goes 0->1.
module spi_clk_div #(
   parameter int DivHalf = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o
);

   localparam int CNT_W = (DivHalf > 2) ? $clog2(DivHalf) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DivHalf - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;

   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (!en_i) begin
         cnt_d  = '0;
         sclk_d = 1'b1;
      end else if (cnt_q == '0) begin
         sclk_d = ~sclk_q;
         cnt_d  = CNT_RELOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         sclk_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   assign rise_o = en_i & ~sclk_q & (cnt_q == '0);

endmodule

// File: rtl/adc_volts_reader.sv
// Averaging SPI ADC reader: 2^AvgLog2 frames of 36*DivHalf cycles, then a one-cycle valid.
// start_i is only sampled in IDLE; requests arriving while busy are dropped, not queued.
module adc_volts_reader #(
   parameter int Width   = 12,
   parameter int DivHalf = 4,
   parameter int AvgLog2 = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             miso_i,
   output logic             cs_o,
   output logic             sclk_o,
   output logic             busy_o,
   output logic             valid_o,
   output logic [Width-1:0] data_o,
   output logic             err_o
);
   import adc_pkg::*;

   localparam int SHIFT_LEN = 2 * FRAME_BITS * DivHalf;
   localparam int TMR_W     = $clog2(SHIFT_LEN);
   localparam int ACC_W     = Width + AvgLog2;
   localparam int SMP_W     = AvgLog2 + 1;
   localparam int BIT_W     = $clog2(FRAME_BITS + 1);

   localparam logic [TMR_W-1:0] EDGE_END  = TMR_W'(DivHalf - 1);
   localparam logic [TMR_W-1:0] SHIFT_END = TMR_W'(SHIFT_LEN - 1);
   localparam logic [TMR_W-1:0] QUIET_END = TMR_W'(2 * DivHalf - 1);
   localparam logic [SMP_W-1:0] LAST_SMP  = SMP_W'((1 << AvgLog2) - 1);

   state_t                  state_q, state_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [SMP_W-1:0]        smp_cnt_q, smp_cnt_d;
   logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic                    err_flag_q, err_flag_d;
   logic                    cs_q, cs_d;
   logic                    busy_q, busy_d;
   logic                    valid_q, valid_d;
   logic [Width-1:0]        data_q, data_d;
   logic                    err_q, err_d;
   logic                    sclk_en;
   logic                    sclk_rise;

   // Enable follows the next state so SCLK drops on the first SHIFT cycle.
   assign sclk_en = (state_d == SHIFT);

   spi_clk_div #(
      .DivHalf (DivHalf)
   ) u_clk_div (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (sclk_en),
      .sclk_o (sclk_o),
      .rise_o (sclk_rise)
   );

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q + 1'b1;
      bit_cnt_d  = bit_cnt_q;
      smp_cnt_d  = smp_cnt_q;
      shreg_d    = shreg_q;
      acc_d      = acc_q;
      err_flag_d = err_flag_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      err_d      = err_q;

      unique case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (start_i) begin
               state_d    = CS_SETUP;
               acc_d      = '0;
               err_flag_d = 1'b0;
               smp_cnt_d  = '0;
            end
         end
         CS_SETUP: begin
            if (tmr_q == EDGE_END) begin
               state_d   = SHIFT;
               tmr_d     = '0;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (sclk_rise) begin
               shreg_d   = {shreg_q[FRAME_BITS-2:0], miso_i};
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
            // The last rising edge lands DivHalf cycles before this point, so shreg_q is complete.
            if (tmr_q == SHIFT_END) begin
               state_d = CS_HOLD;
               tmr_d   = '0;
               acc_d   = acc_q + ACC_W'(shreg_q[Width-1:0]);
               if (shreg_q[FRAME_BITS-1 -: LEAD_ZEROS] != '0) begin
                  err_flag_d = 1'b1;
               end
            end
         end
         CS_HOLD: begin
            if (tmr_q == EDGE_END) begin
               state_d = QUIET;
               tmr_d   = '0;
            end
         end
         QUIET: begin
            if (tmr_q == QUIET_END) begin
               tmr_d     = '0;
               smp_cnt_d = smp_cnt_q + 1'b1;
               state_d   = (smp_cnt_q == LAST_SMP) ? DONE : CS_SETUP;
            end
         end
         DONE: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase

      cs_d   = !((state_d == CS_SETUP) || (state_d == SHIFT) || (state_d == CS_HOLD));
      busy_d = (state_d != IDLE) && (state_d != DONE);
      if (state_d == DONE) begin
         valid_d = 1'b1;
         data_d  = acc_d[ACC_W-1:AvgLog2];
         err_d   = err_flag_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         bit_cnt_q  <= '0;
         smp_cnt_q  <= '0;
         shreg_q    <= '0;
         acc_q      <= '0;
         err_flag_q <= 1'b0;
         cs_q       <= 1'b1;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         bit_cnt_q  <= bit_cnt_d;
         smp_cnt_q  <= smp_cnt_d;
         shreg_q    <= shreg_d;
         acc_q      <= acc_d;
         err_flag_q <= err_flag_d;
         cs_q       <= cs_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         err_q      <= err_d;
      end
   end

   assign cs_o    = cs_q;
   assign busy_o  = busy_q;
   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign err_o   = err_q;

endmodule
